// File: rtl/gap_symbol_packer.sv
// -----------------------------------------------------------------------------
// gap_symbol_packer
// Packs the gap-length classifier's one-cycle result codes into words of 2-bit
// symbols. A word closes on a terminator code or when it reaches MAX_SYMS
// symbols, then is held and offered downstream over a valid/ready handshake.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-low reset
//   sym_in      in   classifier code (000 = no event, 001/010/011 = symbol 0/1/2,
//                    111 = terminator, 100/101/110 = illegal)
//   word_out    out  packed symbols, symbol k at [2k+1:2k]; unused slots are 0
//   word_len    out  number of valid symbols in word_out
//   word_valid  out  word_out/word_len hold a complete word
//   word_ready  in   consumer accepts the word while word_valid is high
//   busy        out  packer is not idle
//   ovf         out  sticky: a symbol arrived while a word was being held
//   err         out  sticky: an illegal code was seen
// -----------------------------------------------------------------------------
module gap_symbol_packer #(
    parameter int unsigned MAX_SYMS = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              sym_in,
    output logic [2*MAX_SYMS-1:0]   word_out,
    output logic [CNT_W-1:0]        word_len,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    busy,
    output logic                    ovf,
    output logic                    err
);

    localparam int unsigned WORD_W = 2 * MAX_SYMS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_word;
    logic [CNT_W-1:0]    r_len;
    logic                r_valid;
    logic                r_busy;
    logic                r_ovf;
    logic                r_err;

    state_t              w_state_nx;
    logic [WORD_W-1:0]   w_word_nx;
    logic [CNT_W-1:0]    w_len_nx;
    logic                w_ovf_nx;
    logic                w_err_nx;

    logic                w_is_sym;
    logic                w_is_term;
    logic                w_illegal;
    logic [1:0]          w_sym;
    logic [CNT_W-1:0]    w_len_inc;
    logic [WORD_W-1:0]   w_slot_ins;

    // Code decode: 001..011 carry a symbol, 111 terminates, 1xx otherwise is illegal
    assign w_is_term = (sym_in == 3'b111);
    assign w_is_sym  = !sym_in[2] && (sym_in[1:0] != 2'b00);
    assign w_illegal = sym_in[2] && !w_is_term;
    assign w_sym     = sym_in[1:0] - 2'd1;
    assign w_len_inc = r_len + CNT_W'(1);

    // New symbol placed in the slot indexed by the current length
    always_comb begin
        w_slot_ins = '0;
        for (int unsigned k = 0; k < MAX_SYMS; k++) begin
            if (CNT_W'(k) == r_len) begin
                w_slot_ins[2*k +: 2] = w_sym;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nx = r_state;
        w_word_nx  = r_word;
        w_len_nx   = r_len;
        w_ovf_nx   = r_ovf;
        w_err_nx   = r_err | w_illegal;

        case (r_state)
            ST_IDLE: begin
                // A terminator with nothing collected is ignored (no empty words)
                if (w_is_sym) begin
                    w_word_nx  = WORD_W'(w_sym);
                    w_len_nx   = CNT_W'(1);
                    w_state_nx = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (w_is_sym) begin
                    // Unused slots are always zero, so OR-ing in the new slot is safe
                    w_word_nx = r_word | w_slot_ins;
                    w_len_nx  = w_len_inc;
                    if (w_len_inc == CNT_W'(MAX_SYMS)) begin
                        w_state_nx = ST_HOLD;
                    end
                end else if (w_is_term) begin
                    w_state_nx = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (word_ready) begin
                    // Handshake; a same-cycle symbol starts the next word directly
                    if (w_is_sym) begin
                        w_word_nx  = WORD_W'(w_sym);
                        w_len_nx   = CNT_W'(1);
                        w_state_nx = ST_COLLECT;
                    end else begin
                        w_word_nx  = '0;
                        w_len_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end
                end else if (w_is_sym) begin
                    w_ovf_nx = 1'b1;
                end
            end

            default: begin
                w_word_nx  = '0;
                w_len_nx   = '0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_word  <= w_word_nx;
            r_len   <= w_len_nx;
            r_valid <= (w_state_nx == ST_HOLD);
            r_busy  <= (w_state_nx != ST_IDLE);
            r_ovf   <= w_ovf_nx;
            r_err   <= w_err_nx;
        end
    end

    assign word_out   = r_word;
    assign word_len   = r_len;
    assign word_valid = r_valid;
    assign busy       = r_busy;
    assign ovf        = r_ovf;
    assign err        = r_err;

endmodule
